// File: rtl/tcb_vip_pkg.sv
// Shared types for the TCB verification IP: check identifiers, frame tracker
// states and the priority encoder that picks the reported check.
package tcb_vip_pkg;

    localparam int TCB_CHK_NUM = 8;

    typedef enum logic [2:0] {
        CHK_RST_VLD  = 3'd0,
        CHK_STL_CHG  = 3'd1,
        CHK_STL_DROP = 3'd2,
        CHK_TMO      = 3'd3,
        CHK_ALN      = 3'd4,
        CHK_SIZ      = 3'd5,
        CHK_LCK      = 3'd6,
        CHK_STS      = 3'd7
    } tcb_chk_e;

    typedef enum logic {
        FRM_IDLE   = 1'b0,
        FRM_LOCKED = 1'b1
    } tcb_frm_e;

    // Lowest-index check that fired; CHK_RST_VLD when nothing fired.
    function automatic tcb_chk_e tcb_chk_first(input logic [TCB_CHK_NUM-1:0] fire);
        tcb_chk_e id;
        id = CHK_RST_VLD;
        for (int i = TCB_CHK_NUM - 1; i >= 0; i--) begin
            if (fire[i]) id = tcb_chk_e'(3'(i));
        end
        return id;
    endfunction

endpackage

// File: rtl/tcb_vip_rsp_pipe.sv
// Response delay line: due goes high DLY cycles after a transfer,
// or in the transfer cycle itself when DLY is zero.
module tcb_vip_rsp_pipe #(
    parameter int DLY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic trn,
    output logic due
);

    generate
        if (DLY == 0) begin : g_comb
            assign due = trn;
        end else begin : g_pipe
            logic [DLY:1] tap;

            always_ff @(posedge clk) begin
                if (rst) begin
                    tap <= '0;
                end else begin
                    tap[1] <= trn;
                    for (int i = 2; i <= DLY; i++) begin
                        tap[i] <= tap[i-1];
                    end
                end
            end

            assign due = tap[DLY];
        end
    endgenerate

endmodule

// File: rtl/tcb_vip_protocol_monitor.sv
// Passive TCB protocol monitor: evaluates eight bus rules every cycle and keeps
// sticky flags, saturating counters and a capture of the first violation.
module tcb_vip_protocol_monitor
    import tcb_vip_pkg::*;
#(
    parameter int ADR     = 32,
    parameter int DAT     = 32,
    parameter int BYT     = DAT / 8,
    parameter int DLY     = 1,
    parameter int TMO     = 64,
    parameter int LCK_MAX = 16,
    parameter int CNT     = 16,
    parameter int SZW     = $clog2(BYT) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vld,
    input  logic                   rdy,
    input  logic                   lck,
    input  logic                   wen,
    input  logic [ADR-1:0]         adr,
    input  logic [SZW-1:0]         siz,
    input  logic [DAT-1:0]         wdt,
    input  logic                   sts,
    input  logic                   clr,
    input  logic [TCB_CHK_NUM-1:0] chk_ena,
    output logic [TCB_CHK_NUM-1:0] err,
    output logic                   err_any,
    output logic [CNT-1:0]         err_cnt,
    output logic [CNT-1:0]         trn_cnt,
    output logic                   fst_vld,
    output logic [2:0]             fst_id,
    output logic [CNT-1:0]         fst_trn
);

    localparam int SIZ_MAX = $clog2(BYT);
    localparam int TMW     = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam int PLW     = 2 + ADR + SZW + DAT;

    function automatic logic [CNT-1:0] sat_inc(input logic [CNT-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic trn;
    logic stl;
    assign trn = vld & rdy;
    assign stl = vld & ~rdy;

    // Handshake history: previous-cycle stall, payload and the post-reset flag.
    logic           pst;
    logic           stl_q;
    logic [PLW-1:0] pld;
    logic [PLW-1:0] pld_q;
    assign pld = {lck, wen, adr, siz, wdt};

    always_ff @(posedge clk) begin
        pst <= rst;
        if (rst) stl_q <= 1'b0;
        else     stl_q <= stl;
    end

    // NOTE: the payload copy needs no reset; it is only looked at when stl_q is set.
    always_ff @(posedge clk) begin
        pld_q <= pld;
    end

    logic [TMW-1:0] stl_cnt;

    always_ff @(posedge clk) begin
        if (rst || !stl) begin
            stl_cnt <= '0;
        end else if (stl_cnt != TMW'(TMO)) begin
            stl_cnt <= stl_cnt + 1'b1;
        end
    end

    tcb_frm_e       frm_state;
    tcb_frm_e       frm_nxt;
    logic           frm_start;
    logic           lck_fire;
    logic           frm_wen;
    logic [CNT-1:0] frm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_state <= FRM_IDLE;
            frm_wen   <= 1'b0;
            frm_cnt   <= '0;
        end else begin
            frm_state <= frm_nxt;
            if (frm_start) begin
                frm_wen <= wen;
                frm_cnt <= CNT'(1);
            end else if (frm_state == FRM_LOCKED && trn) begin
                frm_cnt <= sat_inc(frm_cnt);
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        frm_nxt   = frm_state;
        frm_start = 1'b0;
        lck_fire  = 1'b0;
        case (frm_state)
            FRM_IDLE: begin
                if (trn && lck) begin
                    frm_nxt   = FRM_LOCKED;
                    frm_start = 1'b1;
                end
            end
            FRM_LOCKED: begin
                if (trn) begin
                    if ((LCK_MAX != 0 && frm_cnt >= CNT'(LCK_MAX)) || wen != frm_wen) begin
                        lck_fire = 1'b1;
                    end
                    if (!lck) frm_nxt = FRM_IDLE;
                end
            end
            default: frm_nxt = FRM_IDLE;
        endcase
    end

    logic due;

    tcb_vip_rsp_pipe #(
        .DLY (DLY)
    ) u_rsp_pipe (
        .clk (clk),
        .rst (rst),
        .trn (trn),
        .due (due)
    );

    logic [ADR-1:0]         adr_mask;
    logic                   tmo_hit;
    logic [TCB_CHK_NUM-1:0] fire_raw;
    logic [TCB_CHK_NUM-1:0] fire;
    logic                   fire_any;

    assign adr_mask = ~({ADR{1'b1}} << siz);
    assign tmo_hit  = (TMO > 0) && stl && (stl_cnt == TMW'(TMO - 1));

    // Only the reset-valid rule is live while rst is high.
    always_comb begin
        fire_raw               = '0;
        fire_raw[CHK_RST_VLD]  = vld & (rst | pst);
        fire_raw[CHK_STL_CHG]  = ~rst & stl_q & (pld != pld_q);
        fire_raw[CHK_STL_DROP] = ~rst & stl_q & ~vld;
        fire_raw[CHK_TMO]      = ~rst & tmo_hit;
        fire_raw[CHK_ALN]      = ~rst & trn & (|(adr & adr_mask));
        fire_raw[CHK_SIZ]      = ~rst & trn & (siz > SZW'(SIZ_MAX));
        fire_raw[CHK_LCK]      = ~rst & lck_fire;
        fire_raw[CHK_STS]      = ~rst & sts & due;
    end

    assign fire     = fire_raw & chk_ena;
    assign fire_any = |fire;

    // Reset and clr both start from a clean slate; a same-cycle error still lands.
    logic                   wipe;
    logic [TCB_CHK_NUM-1:0] err_base;
    logic [CNT-1:0]         err_cnt_base;
    logic [CNT-1:0]         trn_cnt_base;
    logic                   fst_vld_base;

    assign wipe         = rst | clr;
    assign err_base     = wipe ? '0 : err;
    assign err_cnt_base = wipe ? '0 : err_cnt;
    assign trn_cnt_base = wipe ? '0 : trn_cnt;
    assign fst_vld_base = wipe ? 1'b0 : fst_vld;

    always_ff @(posedge clk) begin
        err     <= err_base | fire;
        err_cnt <= fire_any ? sat_inc(err_cnt_base) : err_cnt_base;
        trn_cnt <= (trn && !rst) ? sat_inc(trn_cnt_base) : trn_cnt_base;
        if (fire_any && !fst_vld_base) begin
            fst_vld <= 1'b1;
            fst_id  <= tcb_chk_first(fire);
            fst_trn <= trn_cnt_base;
        end else if (wipe) begin
            fst_vld <= 1'b0;
            fst_id  <= '0;
            fst_trn <= '0;
        end
    end

    assign err_any = |err;

endmodule

// File: tb/tb_tcb_vip_protocol_monitor.sv
// Directed bench for the TCB protocol monitor: one scenario per check,
// plus clear/reset interaction and counter saturation.
module tb_tcb_vip_protocol_monitor;

    localparam int ADR     = 32;
    localparam int DAT     = 32;
    localparam int DLY     = 2;
    localparam int TMO     = 4;
    localparam int LCK_MAX = 4;
    localparam int CNT     = 4;
    localparam int SZW     = 3;

    logic            clk;
    logic            rst;
    logic            vld;
    logic            rdy;
    logic            lck;
    logic            wen;
    logic [ADR-1:0]  adr;
    logic [SZW-1:0]  siz;
    logic [DAT-1:0]  wdt;
    logic            sts;
    logic            clr;
    logic [7:0]      chk_ena;
    logic [7:0]      err;
    logic            err_any;
    logic [CNT-1:0]  err_cnt;
    logic [CNT-1:0]  trn_cnt;
    logic            fst_vld;
    logic [2:0]      fst_id;
    logic [CNT-1:0]  fst_trn;

    int n_chk = 0;
    int n_err = 0;

    tcb_vip_protocol_monitor #(
        .ADR     (ADR),
        .DAT     (DAT),
        .DLY     (DLY),
        .TMO     (TMO),
        .LCK_MAX (LCK_MAX),
        .CNT     (CNT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .vld     (vld),
        .rdy     (rdy),
        .lck     (lck),
        .wen     (wen),
        .adr     (adr),
        .siz     (siz),
        .wdt     (wdt),
        .sts     (sts),
        .clr     (clr),
        .chk_ena (chk_ena),
        .err     (err),
        .err_any (err_any),
        .err_cnt (err_cnt),
        .trn_cnt (trn_cnt),
        .fst_vld (fst_vld),
        .fst_id  (fst_id),
        .fst_trn (fst_trn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then read 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        vld = 1'b0; rdy = 1'b0; lck = 1'b0; wen = 1'b0;
        adr = '0;   siz = 3'd2; wdt = '0;   sts = 1'b0;
    endtask

    task automatic xfer(input logic l, input logic w, input logic [31:0] a, input logic [2:0] s);
        vld = 1'b1; rdy = 1'b1; lck = l; wen = w; adr = a; siz = s;
        step();
    endtask

    task automatic do_clr();
        bus_idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; chk_ena = 8'hFF;
        bus_idle();
        step();
        step();
        check("rst_err",     err,     8'h00);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_trn_cnt", trn_cnt, 0);
        check("rst_fst_vld", fst_vld, 0);

        // Valid in the first cycle after reset release.
        rst = 1'b0;
        xfer(1'b0, 1'b0, 32'h0, 3'd2);
        check("rstvld_err",     err,     8'h01);
        check("rstvld_fst_id",  fst_id,  0);
        check("rstvld_fst_trn", fst_trn, 0);
        check("rstvld_trn_cnt", trn_cnt, 1);
        bus_idle();
        step();
        check("rstvld_err_any", err_any, 1);
        do_clr();
        check("clr_err",     err,     8'h00);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_trn_cnt", trn_cnt, 0);
        check("clr_fst_vld", fst_vld, 0);
        check("clr_err_any", err_any, 0);

        // Address changes during a 3-cycle stall.
        vld = 1'b1; rdy = 1'b0; adr = 32'h10;
        step();
        adr = 32'h14;
        step();
        step();
        rdy = 1'b1;
        step();
        bus_idle();
        step();
        check("stlchg_err",     err,     8'h02);
        check("stlchg_err_cnt", err_cnt, 1);
        check("stlchg_fst_id",  fst_id,  1);
        check("stlchg_trn_cnt", trn_cnt, 1);
        do_clr();

        // Six-cycle stall against TMO=4.
        vld = 1'b1; rdy = 1'b0; adr = 32'h20;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 3) check("tmo_before", err, 8'h00);
            if (i == 4) check("tmo_hit",    err, 8'h08);
        end
        rdy = 1'b1;
        step();
        bus_idle();
        step();
        check("tmo_err",     err,     8'h08);
        check("tmo_err_cnt", err_cnt, 1);
        do_clr();

        // Stall followed by a dropped valid.
        vld = 1'b1; rdy = 1'b0; adr = 32'h30;
        step();
        vld = 1'b0;
        step();
        check("drop_err", err, 8'h04);
        do_clr();

        // Alignment and size rules.
        xfer(1'b0, 1'b0, 32'h2, 3'd1);
        bus_idle();
        step();
        check("aln_ok", err, 8'h00);
        xfer(1'b0, 1'b0, 32'h2, 3'd2);
        bus_idle();
        step();
        check("aln_err", err, 8'h10);
        do_clr();
        xfer(1'b0, 1'b0, 32'h0, 3'd3);
        bus_idle();
        step();
        check("siz_err", err, 8'h20);
        do_clr();
        xfer(1'b0, 1'b0, 32'h2, 3'd3);
        bus_idle();
        step();
        check("alnsiz_err",     err,     8'h30);
        check("alnsiz_err_cnt", err_cnt, 1);
        check("alnsiz_fst_id",  fst_id,  4);
        check("alnsiz_fst_trn", fst_trn, 0);
        do_clr();

        // Disabled check stays silent.
        chk_ena = 8'hEF;
        xfer(1'b0, 1'b0, 32'h2, 3'd2);
        bus_idle();
        step();
        check("dis_err",     err,     8'h00);
        check("dis_err_cnt", err_cnt, 0);
        chk_ena = 8'hFF;
        do_clr();

        // Locked frame of five transfers with LCK_MAX=4.
        for (int i = 1; i <= 4; i++) xfer(1'b1, 1'b0, 32'h40, 3'd2);
        check("lck4_err", err, 8'h00);
        xfer(1'b0, 1'b0, 32'h40, 3'd2);
        check("lck5_err",     err,     8'h40);
        check("lck5_trn_cnt", trn_cnt, 5);
        check("lck5_fst_trn", fst_trn, 4);
        bus_idle();
        do_clr();

        // Write enable flips inside a frame.
        xfer(1'b1, 1'b0, 32'h50, 3'd2);
        check("wen1_err", err, 8'h00);
        xfer(1'b0, 1'b1, 32'h50, 3'd2);
        check("wen2_err", err, 8'h40);
        bus_idle();
        do_clr();

        // Error status two cycles after a transfer.
        xfer(1'b0, 1'b0, 32'h60, 3'd2);
        bus_idle();
        step();
        check("sts_wait", err, 8'h00);
        sts = 1'b1;
        step();
        sts = 1'b0;
        check("sts_err", err, 8'h80);
        step();
        do_clr();
        step();
        step();
        sts = 1'b1;
        step();
        step();
        sts = 1'b0;
        check("sts_none_err",     err,     8'h00);
        check("sts_none_err_cnt", err_cnt, 0);

        // Clear coincident with a new alignment error.
        xfer(1'b0, 1'b0, 32'h0, 3'd3);
        bus_idle();
        check("pre_clr_err", err, 8'h20);
        clr = 1'b1;
        xfer(1'b0, 1'b0, 32'h2, 3'd2);
        clr = 1'b0;
        bus_idle();
        check("clrerr_err",     err,     8'h10);
        check("clrerr_err_cnt", err_cnt, 1);
        check("clrerr_fst_vld", fst_vld, 1);
        check("clrerr_fst_id",  fst_id,  4);
        check("clrerr_fst_trn", fst_trn, 0);
        do_clr();

        // Transfer counter saturation: 2**CNT+3 transfers.
        for (int i = 1; i <= 19; i++) begin
            xfer(1'b0, 1'b0, 32'h0, 3'd2);
            if (i == 14) check("trn_cnt_14", trn_cnt, 14);
        end
        bus_idle();
        step();
        check("trn_cnt_sat", trn_cnt, 15);
        check("sat_err",     err,     8'h00);
        do_clr();

        // Reset during a stall abandons it; valid during reset is reported.
        vld = 1'b1; rdy = 1'b0; adr = 32'h70;
        step();
        bus_idle();
        rst = 1'b1;
        step();
        check("rst_stl_err", err, 8'h00);
        rst = 1'b0;
        step();
        check("rst_stl_after", err, 8'h00);
        rst = 1'b1; vld = 1'b1;
        step();
        check("rst_vld_in_rst", err, 8'h01);
        check("rst_vld_fst_id", fst_id, 0);
        vld = 1'b0;
        step();
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tcb_vip_protocol_monitor.md
# tcb_vip_protocol_monitor

Synthesizable, parametrised TCB protocol monitor: the next generation of the simulation-only protocol checker. It adds registered, observable results: sticky per-check error flags, saturating error and transfer counters, first-error capture, a stall timeout, lock-frame length limits, and alignment checks. It sits passively beside any TCB manager/subordinate pair, in simulation benches or FPGA debug builds, and never drives the bus.

## Interface
- ADR, 32, address width
- DAT, 32, data width; BYT = DAT/8, power of two
- DLY, 1, response delay in cycles (0..7)
- TMO, 64, max consecutive stall cycles; 0 disables the timeout check
- LCK_MAX, 16, max transfers in one locked frame; 0 disables the check
- CNT, 16, counter width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- vld  in  1  request valid
- rdy  in  1  request ready
- lck  in  1  frame lock
- wen  in  1  write enable
- adr  in  ADR  address
- siz  in  $clog2(BYT)+1  log2 transfer size
- wdt  in  DAT  write data
- sts  in  1  response error status, sampled DLY cycles after a transfer
- clr  in  1  clear sticky flags, counters and capture
- chk_ena  in  8  per-check enable mask
- err  out  8  sticky error flags, indexed by check ID
- err_any  out  1  OR of err
- err_cnt  out  CNT  saturating count of error cycles
- trn_cnt  out  CNT  saturating count of transfers (vld & rdy)
- fst_vld  out  1  first-error capture valid
- fst_id  out  3  ID of the lowest-index check that fired in the first error cycle
- fst_trn  out  CNT  trn_cnt value at the first error

## Operation
- Transfer: trn = vld & rdy. Stall: stl = vld & ~rdy.
- Check IDs:
  - 0 RST_VLD: vld high during rst, or in the first cycle after rst falls.
  - 1 STL_CHG: lck/wen/adr/siz/wdt change in a cycle that follows stl.
  - 2 STL_DROP: vld low in a cycle that follows stl.
  - 3 TMO: stall counter reaches TMO.
  - 4 ALN: on trn, adr & (2**siz-1) != 0.
  - 5 SIZ: on trn, siz > $clog2(BYT).
  - 6 LCK: locked-frame transfer count exceeds LCK_MAX, or wen differs from the frame's first transfer.
  - 7 STS: sts high while the response pipe reports a response due.
- A check fires only if its chk_ena bit is set. A disabled check never sets err, never counts, and is never captured.
- Stall counter: increments on stl and clears on any non-stall cycle. It saturates at TMO, so TMO fires once per stall.
- Frame tracker:
  - States: IDLE, LOCKED.
  - IDLE -> LOCKED on trn with lck=1. Records wen and sets the frame count to 1.
  - LOCKED increments the count on each trn.
  - LOCKED -> IDLE on trn with lck=0. That transfer is the last of the frame and is counted.
- Response pipe: a DLY-deep shift of trn. A response is due when the tap at depth DLY is 1. With DLY=0 the response is due in the transfer cycle itself.
- err_cnt increments by 1 per cycle in which any enabled check fires, whatever the number of checks.
- First error: on the first firing cycle while fst_vld=0, capture fst_id and fst_trn (the pre-increment trn_cnt), then set fst_vld.
- Clear: clr zeroes err, the counters and the capture. If a check fires in the same cycle as clr, the new error wins: its err bit is set, err_cnt becomes 1, and the capture is taken.

## Timing
- Checks evaluate combinationally on cycle N inputs. err, err_cnt, trn_cnt and fst_* update at the N+1 edge. err_any is combinational from err.
- Reset clears err, err_cnt, trn_cnt, fst_*, the stall counter, the frame tracker (to IDLE) and the response pipe. It also sets a one-cycle post-reset flag used by check 0.
- Reset during a stall or a locked frame abandons it silently: no STL_DROP and no LCK is reported.
- Counters hold at 2**CNT-1.
- No other check evaluates while rst=1.

## Structure
- tcb_vip_pkg gains:
  - tcb_chk_e, the check ID enum 0..7
  - TCB_CHK_NUM = 8
- Sub-module tcb_vip_rsp_pipe (parameter DLY; ports clk, rst, trn, due) implements the response delay line.

## Test plan
- vld=1 on the first cycle after rst falls -> err[0]=1 next cycle, fst_id=0, fst_trn=0.
- Stall 3 cycles with adr changing 0x10->0x14 in the 2nd stall cycle -> err[1]=1, err_cnt=1. A stall with TMO=4 lasting 6 cycles -> err[3] set exactly once.
- trn with siz=2, adr=0x02 -> err[4]=1. trn with siz=3 and DAT=32 -> err[5]=1. Both in one cycle -> err_cnt=1, fst_id=4.
- LCK_MAX=4, locked frame of 5 transfers -> err[6] on the 5th. A frame with wen 0 then 1 -> err[6] on the 2nd.
- DLY=2, sts=1 two cycles after trn -> err[7]. sts=1 with no response due -> no error.
- clr coincident with an ALN violation -> err=0x10, err_cnt=1, fst_vld=1. 2**CNT+3 transfers -> trn_cnt saturated at all-ones.
